// File: rtl/bit_serial_adder.sv
// Bit-serial N-bit adder: operands enter over valid/ready and are added LSB-first, one bit per clock.
// The result leaves over a second valid/ready handshake. Define OVERFLOW_EN to add the registered signed-overflow output ovf.
module bit_serial_adder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         busy
`ifdef OVERFLOW_EN
   ,
   output logic         ovf
`endif
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  a_sh_q, a_sh_d;
   logic [N-1:0]  b_sh_q, b_sh_d;
   logic [N-1:0]  psum_q, psum_d;
   logic          carry_q, carry_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
`ifdef OVERFLOW_EN
   logic          ovf_q, ovf_d;
`endif

   logic bit_s;
   logic bit_c;

   // Single-bit add cell shared by every bit position.
   assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      psum_d  = psum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d  = {1'b0, a_sh_q[N-1:1]};
            b_sh_d  = {1'b0, b_sh_q[N-1:1]};
            psum_d  = {bit_s, psum_q[N-1:1]};
            carry_d = bit_c;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // carry_q is the carry into the MSB; bit_c is the carry out of it.
               state_d = S_DONE;
               cnt_d   = '0;
               sum_d   = {bit_s, psum_q[N-1:1]};
               cout_d  = bit_c;
`ifdef OVERFLOW_EN
               ovf_d   = carry_q ^ bit_c;
`endif
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         psum_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         psum_q  <= psum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef OVERFLOW_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = rst_n && (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef OVERFLOW_EN
   assign ovf       = ovf_q;
`endif

endmodule
